branch_resolve: RTL and testbench
=================================

# branch_resolve

Branch resolution unit for the ID stage of the MIPS pipeline. It consumes the register-compare flags (unequal flag and zero/positive/negative class of rs) together with the decoded branch/jump opcode, and decides taken/not-taken. It computes the target and link value, waits for the delay-slot instruction to issue, then presents a redirect to the fetch stage with a valid/ready handshake. It sits between the operand comparator and the IF-stage PC mux.

## Interface
- No parameters; widths fixed at 32-bit address/data.
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- br_valid  in  1  ID holds a branch/jump with operands ready
- br_ready  out  1  unit can accept a branch (high only in IDLE)
- br_op  in  4  branch opcode (package encoding)
- br_pc  in  32  PC of the branch instruction
- br_imm16  in  16  branch offset field
- br_idx26  in  26  jump index field
- rs_value  in  32  forwarded GPR[rs] (JR/JALR target)
- cmp_ne  in  1  1 = GPR[rs] != GPR[rt]
- cmp_sign  in  2  class of GPR[rs]: 00 zero, 01 positive, 10 negative
- ds_valid  in  1  delay-slot instruction issued from ID this cycle
- flush  in  1  exception/eret flush from later stage
- br_taken  out  1  one-cycle pulse: accepted branch resolved taken
- link_we  out  1  one-cycle pulse: link write required
- link_value  out  32  br_pc + 8, valid with link_we
- adel_req  out  1  one-cycle pulse: JR/JALR target[1:0] != 0
- redirect_valid  out  1  redirect target available to IF
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  IF accepts redirect

## Operation
- Acceptance: br_valid && br_ready at rising edge; all br_* and cmp_* inputs sampled that cycle.
- Condition: BEQ !cmp_ne; BNE cmp_ne; BGEZ/BGEZAL cmp_sign!=10; BGTZ cmp_sign==01; BLEZ cmp_sign!=01; BLTZ/BLTZAL cmp_sign==10; J/JAL/JR/JALR always taken. cmp_sign==11 is treated as negative (bit 1 governs).
- Target: branches (br_pc+4) + {sext(br_imm16),2'b00}, 32-bit wrap-around; J/JAL {pc4[31:28],br_idx26,2'b00} with pc4 = br_pc+4; JR/JALR rs_value.
- Link: JAL/JALR/BGEZAL/BLTZAL assert link_we whether taken or not; link_value = br_pc+8, modulo 2^32.
- Misaligned JR/JALR target: pulse adel_req, treat as not taken, and issue no redirect.
- FSM states:
  - IDLE: accept a branch. Taken → WAIT_DS; otherwise stay in IDLE.
  - WAIT_DS: on ds_valid → REDIRECT.
  - REDIRECT: on redirect_valid && redirect_ready → IDLE.
- Target is latched at acceptance and held unchanged until the handshake completes.
- flush in any state → IDLE next cycle; a pending redirect is dropped. flush has priority over ds_valid, redirect_ready and br_valid in the same cycle. A branch presented during flush is not accepted.
- Reset: state IDLE; br_taken, link_we, adel_req, redirect_valid 0; redirect_pc, link_value 0; br_ready 1 once reset deasserts.

## Timing
- Branch accepted in cycle N: br_taken, link_we, link_value and adel_req are registered and valid in N+1, for exactly one cycle.
- WAIT_DS is entered in N+1. The earliest ds_valid sampled is at the N+1 edge, so the earliest redirect_valid is N+2.
- redirect_valid is held high, with redirect_pc stable, until the cycle in which redirect_ready is high. It drops the next cycle.
- br_ready is low from N+1 until the cycle after the handshake. Back-to-back branches are therefore impossible; this is correct because a branch in a delay slot is UNPREDICTABLE.
- Not-taken branch: br_ready is low for no cycles and the unit can accept again in N+1.

## Structure
- Shared package: br_op encodings (BEQ=0, BNE=1, BGEZ=2, BGTZ=3, BLEZ=4, BLTZ=5, BGEZAL=6, BLTZAL=7, J=8, JAL=9, JR=10, JALR=11; 12–15 are reserved and treated as not taken with no link), cmp_sign constants, and FSM state encoding.
- One natural sub-module: br_target_gen, a combinational unit producing target, link_value and the misalignment flag.

## Test plan
- BEQ at pc 0x0000_1000, imm 0x0004, cmp_ne=0; ds_valid in N+2, redirect_ready high → br_taken in N+1, redirect_pc 0x0000_1014 valid N+3 for one cycle.
- BLTZAL at pc 0x8000_0000 with cmp_sign=01 → not taken; link_we=1, link_value 0x8000_0008 in N+1; no redirect; br_ready stays 1.
- J at pc 0xBFC0_0100, idx 0x0000040, ds_valid in N+1, redirect_ready low for 3 cycles → redirect_pc 0xB000_0100 is held stable and the handshake completes on the 4th cycle.
- JR with rs_value 0x0040_0002 → adel_req pulse in N+1; br_taken 0; no redirect.
- BNE taken, then flush asserted together with ds_valid in WAIT_DS → IDLE next cycle; redirect_valid never asserts.
- resetn pulled low while in REDIRECT → redirect_valid 0 immediately; state IDLE and br_ready 1 after release.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit.
//   - br_op encodings driven by the ID-stage decoder
//   - cmp_sign class constants from the operand comparator
//   - FSM state encoding
//   - helper functions for the branch condition and the link decision
package branch_resolve_pkg;

    localparam logic [3:0] OP_BEQ    = 4'd0;
    localparam logic [3:0] OP_BNE    = 4'd1;
    localparam logic [3:0] OP_BGEZ   = 4'd2;
    localparam logic [3:0] OP_BGTZ   = 4'd3;
    localparam logic [3:0] OP_BLEZ   = 4'd4;
    localparam logic [3:0] OP_BLTZ   = 4'd5;
    localparam logic [3:0] OP_BGEZAL = 4'd6;
    localparam logic [3:0] OP_BLTZAL = 4'd7;
    localparam logic [3:0] OP_J      = 4'd8;
    localparam logic [3:0] OP_JAL    = 4'd9;
    localparam logic [3:0] OP_JR     = 4'd10;
    localparam logic [3:0] OP_JALR   = 4'd11;

    localparam logic [1:0] SGN_ZERO = 2'b00;
    localparam logic [1:0] SGN_POS  = 2'b01;
    localparam logic [1:0] SGN_NEG  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_DS  = 2'd1,
        ST_REDIRECT = 2'd2
    } br_state_t;

    // Raw branch condition, before the misaligned-target override.
    // Bit 1 of cmp_sign alone marks negative, so the unused code 11 is negative.
    function automatic logic br_cond(input logic [3:0] op,
                                     input logic       ne,
                                     input logic [1:0] sign);
        logic neg;
        logic pos;
        logic res;
        neg = sign[1];
        pos = !sign[1] && sign[0];
        case (op)
            OP_BEQ:                      res = !ne;
            OP_BNE:                      res = ne;
            OP_BGEZ, OP_BGEZAL:          res = !neg;
            OP_BGTZ:                     res = pos;
            OP_BLEZ:                     res = !pos;
            OP_BLTZ, OP_BLTZAL:          res = neg;
            OP_J, OP_JAL, OP_JR, OP_JALR: res = 1'b1;
            default:                     res = 1'b0;
        endcase
        return res;
    endfunction

    // Link-writing ops write r31/rd regardless of the branch outcome.
    function automatic logic br_link(input logic [3:0] op);
        return (op == OP_JAL) || (op == OP_JALR) ||
               (op == OP_BGEZAL) || (op == OP_BLTZAL);
    endfunction

endpackage

// File: rtl/branch_resolve_br_target_gen.sv
// Combinational target/link generator.
//   op, pc, imm16, idx26, rs_value : decoded branch fields and forwarded rs
//   target     : branch/jump destination (32-bit wrap-around)
//   link_value : pc + 8
//   misalign   : JR/JALR destination not word aligned
module br_target_gen
    import branch_resolve_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    input  logic [25:0] idx26,
    input  logic [31:0] rs_value,
    output logic [31:0] target,
    output logic [31:0] link_value,
    output logic        misalign
);

    logic [31:0] pc4;
    logic [31:0] rel_target;
    logic [31:0] abs_target;
    logic        is_reg_jump;

    assign pc4         = pc + 32'd4;
    assign rel_target  = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    // Jump stays in the 256 MB region of the delay slot, hence pc4 not pc.
    assign abs_target  = {pc4[31:28], idx26, 2'b00};
    assign is_reg_jump = (op == OP_JR) || (op == OP_JALR);

    always_comb begin
        target = rel_target;
        case (op)
            OP_J, OP_JAL:   target = abs_target;
            OP_JR, OP_JALR: target = rs_value;
            default:        target = rel_target;
        endcase
    end

    assign link_value = pc + 32'd8;
    assign misalign   = is_reg_jump && (rs_value[1:0] != 2'b00);

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit for the ID stage.
// Resolves a branch/jump from the comparator flags, pulses br_taken /
// link_we / adel_req one cycle after acceptance, waits for the delay-slot
// instruction, then offers the target to IF with a valid/ready handshake.
//   clk, resetn          : clock, async active-low reset
//   br_valid/br_ready    : branch acceptance handshake (ready only in IDLE)
//   br_op..br_idx26      : decoded branch fields
//   rs_value             : forwarded GPR[rs]
//   cmp_ne, cmp_sign     : comparator flags
//   ds_valid             : delay slot issued this cycle
//   flush                : pipeline flush, overrides everything
//   br_taken, link_we, link_value, adel_req : registered one-cycle results
//   redirect_valid/ready, redirect_pc       : redirect handshake to IF
module branch_resolve
    import branch_resolve_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [3:0]  br_op,
    input  logic [31:0] br_pc,
    input  logic [15:0] br_imm16,
    input  logic [25:0] br_idx26,
    input  logic [31:0] rs_value,
    input  logic        cmp_ne,
    input  logic [1:0]  cmp_sign,
    input  logic        ds_valid,
    input  logic        flush,
    output logic        br_taken,
    output logic        link_we,
    output logic [31:0] link_value,
    output logic        adel_req,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    br_state_t   state, state_nxt;

    logic [31:0] tgt;
    logic [31:0] link_calc;
    logic        misalign;
    logic        accept;
    logic        taken_eff;

    br_target_gen u_tgt (
        .op         (br_op),
        .pc         (br_pc),
        .imm16      (br_imm16),
        .idx26      (br_idx26),
        .rs_value   (rs_value),
        .target     (tgt),
        .link_value (link_calc),
        .misalign   (misalign)
    );

    assign accept    = br_valid && br_ready;
    // A misaligned register jump raises AdEL instead of redirecting.
    assign taken_eff = br_cond(br_op, cmp_ne, cmp_sign) && !misalign;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; flush wins over every other event.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (accept && taken_eff) state_nxt = ST_WAIT_DS;
                ST_WAIT_DS:  if (ds_valid)            state_nxt = ST_REDIRECT;
                ST_REDIRECT: if (redirect_ready)      state_nxt = ST_IDLE;
                default:                              state_nxt = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs. br_ready drops during flush so a branch
    // offered in that cycle is never handshaken.
    always_comb begin
        br_ready       = 1'b0;
        redirect_valid = 1'b0;
        case (state)
            ST_IDLE:     br_ready       = !flush;
            ST_REDIRECT: redirect_valid = 1'b1;
            default:     ;
        endcase
    end

    // One-cycle result pulses and held values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_taken    <= 1'b0;
            link_we     <= 1'b0;
            adel_req    <= 1'b0;
            link_value  <= 32'd0;
            redirect_pc <= 32'd0;
        end else begin
            br_taken <= accept && taken_eff;
            link_we  <= accept && br_link(br_op);
            adel_req <= accept && misalign;
            if (accept) link_value <= link_calc;
            // Target only moves on a taken acceptance, so it stays put
            // through WAIT_DS and REDIRECT.
            if (accept && taken_eff) redirect_pc <= tgt;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve. Inputs change 1 ns after the rising
// edge; outputs are checked 1 ns after that, within the same cycle.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        resetn;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_op;
    logic [31:0] br_pc;
    logic [15:0] br_imm16;
    logic [25:0] br_idx26;
    logic [31:0] rs_value;
    logic        cmp_ne;
    logic [1:0]  cmp_sign;
    logic        ds_valid;
    logic        flush;
    logic        br_taken;
    logic        link_we;
    logic [31:0] link_value;
    logic        adel_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk            (clk),
        .resetn         (resetn),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_op          (br_op),
        .br_pc          (br_pc),
        .br_imm16       (br_imm16),
        .br_idx26       (br_idx26),
        .rs_value       (rs_value),
        .cmp_ne         (cmp_ne),
        .cmp_sign       (cmp_sign),
        .ds_valid       (ds_valid),
        .flush          (flush),
        .br_taken       (br_taken),
        .link_we        (link_we),
        .link_value     (link_value),
        .adel_req       (adel_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [31:0] pc,
                         input logic [15:0] imm, input logic [25:0] idx,
                         input logic [31:0] rs, input logic ne, input logic [1:0] sgn);
        br_valid = 1'b1; br_op = op; br_pc = pc; br_imm16 = imm;
        br_idx26 = idx; rs_value = rs; cmp_ne = ne; cmp_sign = sgn;
    endtask

    initial begin
        resetn = 1'b0; br_valid = 1'b0; br_op = 4'd0; br_pc = 32'd0;
        br_imm16 = 16'd0; br_idx26 = 26'd0; rs_value = 32'd0; cmp_ne = 1'b0;
        cmp_sign = 2'b00; ds_valid = 1'b0; flush = 1'b0; redirect_ready = 1'b0;
        #2;
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_br_taken", br_taken, 0);
        chk("rst_link_we", link_we, 0);
        chk("rst_adel", adel_req, 0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_link_value", link_value, 32'h0);
        step(); step();
        resetn = 1'b1;
        step();
        chk("post_rst_ready", br_ready, 1);

        // BEQ taken, ds in N+2, ready high
        offer(4'd0, 32'h0000_1000, 16'h0004, 26'd0, 32'd0, 1'b0, 2'b00);
        redirect_ready = 1'b1;
        #1 chk("beq_ready_N", br_ready, 1);
        step(); br_valid = 1'b0;                      // N+1
        #1 chk("beq_taken_N1", br_taken, 1);
        chk("beq_ready_N1", br_ready, 0);
        chk("beq_rv_N1", redirect_valid, 0);
        step(); ds_valid = 1'b1;                      // N+2
        #1 chk("beq_taken_N2", br_taken, 0);
        chk("beq_rv_N2", redirect_valid, 0);
        step(); ds_valid = 1'b0;                      // N+3
        #1 chk("beq_rv_N3", redirect_valid, 1);
        chk("beq_pc_N3", redirect_pc, 32'h0000_1014);
        step();                                       // N+4
        chk("beq_rv_N4", redirect_valid, 0);
        chk("beq_ready_N4", br_ready, 1);
        redirect_ready = 1'b0;

        // BLTZAL not taken, still links
        offer(4'd7, 32'h8000_0000, 16'h0010, 26'd0, 32'd0, 1'b0, 2'b01);
        step(); br_valid = 1'b0;
        #1 chk("bltzal_link_we", link_we, 1);
        chk("bltzal_link_value", link_value, 32'h8000_0008);
        chk("bltzal_taken", br_taken, 0);
        chk("bltzal_ready", br_ready, 1);
        step();
        chk("bltzal_link_we_N2", link_we, 0);
        chk("bltzal_rv_N2", redirect_valid, 0);

        // J, ds in N+1, ready low 3 cycles
        offer(4'd8, 32'hBFC0_0100, 16'h0000, 26'h0000040, 32'd0, 1'b0, 2'b00);
        step(); br_valid = 1'b0; ds_valid = 1'b1;     // N+1
        #1 chk("j_taken", br_taken, 1);
        chk("j_link_we", link_we, 0);
        step(); ds_valid = 1'b0;                      // N+2
        for (int i = 0; i < 3; i++) begin
            chk("j_rv_hold", redirect_valid, 1);
            chk("j_pc_hold", redirect_pc, 32'hB000_0100);
            chk("j_ready_low", br_ready, 0);
            step();
        end
        redirect_ready = 1'b1;
        #1 chk("j_rv_hs", redirect_valid, 1);
        chk("j_pc_hs", redirect_pc, 32'hB000_0100);
        step(); redirect_ready = 1'b0;
        #1 chk("j_rv_after", redirect_valid, 0);
        chk("j_ready_after", br_ready, 1);

        // JR misaligned
        offer(4'd10, 32'h0000_2000, 16'h0000, 26'd0, 32'h0040_0002, 1'b0, 2'b00);
        step(); br_valid = 1'b0; ds_valid = 1'b1;
        #1 chk("jr_adel", adel_req, 1);
        chk("jr_taken", br_taken, 0);
        chk("jr_ready", br_ready, 1);
        step(); ds_valid = 1'b0;
        #1 chk("jr_adel_N2", adel_req, 0);
        chk("jr_rv_N2", redirect_valid, 0);

        // BNE taken (backward), flush with ds_valid in WAIT_DS
        offer(4'd1, 32'h0000_2000, 16'hFFFF, 26'd0, 32'd0, 1'b1, 2'b00);
        step(); br_valid = 1'b0; flush = 1'b1; ds_valid = 1'b1;
        #1 chk("bne_taken", br_taken, 1);
        chk("bne_ready_wait", br_ready, 0);
        step(); flush = 1'b0; ds_valid = 1'b0;
        #1 chk("bne_rv_after_flush", redirect_valid, 0);
        chk("bne_ready_after_flush", br_ready, 1);
        chk("bne_pc_latched", redirect_pc, 32'h0000_2000);
        step();
        chk("bne_rv_N3", redirect_valid, 0);

        // Branch offered during flush is not accepted
        offer(4'd8, 32'h0000_3000, 16'h0000, 26'h0000010, 32'd0, 1'b0, 2'b00);
        flush = 1'b1;
        #1 chk("flush_ready", br_ready, 0);
        step(); br_valid = 1'b0; flush = 1'b0;
        #1 chk("flush_no_take", br_taken, 0);
        chk("flush_idle_ready", br_ready, 1);

        // BGEZ with cmp_sign 11 counts as negative -> not taken
        offer(4'd2, 32'h0000_4000, 16'h0004, 26'd0, 32'd0, 1'b0, 2'b11);
        step(); br_valid = 1'b0;
        #1 chk("bgez_sign11", br_taken, 0);
        chk("bgez_ready", br_ready, 1);

        // BLEZ with cmp_sign 00 -> taken; drop via flush
        offer(4'd4, 32'h0000_4000, 16'h0004, 26'd0, 32'd0, 1'b0, 2'b00);
        step(); br_valid = 1'b0; flush = 1'b1;
        #1 chk("blez_zero", br_taken, 1);
        step(); flush = 1'b0;

        // Reserved op: no take, no link
        offer(4'd13, 32'h0000_5000, 16'h0004, 26'd0, 32'd0, 1'b0, 2'b00);
        step(); br_valid = 1'b0;
        #1 chk("rsv_taken", br_taken, 0);
        chk("rsv_link", link_we, 0);

        // JAL, then reset while in REDIRECT
        offer(4'd9, 32'h0040_0000, 16'h0000, 26'h0000100, 32'd0, 1'b0, 2'b00);
        step(); br_valid = 1'b0; ds_valid = 1'b1;
        #1 chk("jal_taken", br_taken, 1);
        chk("jal_link_we", link_we, 1);
        chk("jal_link_value", link_value, 32'h0040_0008);
        step(); ds_valid = 1'b0;
        #1 chk("jal_rv", redirect_valid, 1);
        chk("jal_pc", redirect_pc, 32'h0000_0400);
        resetn = 1'b0;
        #1 chk("mid_rst_rv", redirect_valid, 0);
        chk("mid_rst_pc", redirect_pc, 32'h0);
        chk("mid_rst_link_value", link_value, 32'h0);
        step();
        resetn = 1'b1;
        step();
        chk("rel_ready", br_ready, 1);
        chk("rel_rv", redirect_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
